fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly downstream of the program counter register. It reads the current `pc`, issues a request/acknowledge read to instruction memory, and buffers returned instructions in a small fetch queue for decode. It drives the program counter's write-enable and next value, `PCWrite` and `n_pc`, for sequential advance and for redirects from branch/jump resolution.

## Interface
- `W`, 32, address/PC width
- `DEPTH`, 2, fetch queue entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pc`  in  W  current PC from PC register
- `PCWrite`  out  1  PC register write enable
- `n_pc`  out  W  next PC value to PC register
- `imem_req`  out  1  instruction memory read request
- `imem_addr`  out  W  request address (registered)
- `imem_ack`  in  1  memory response valid, one cycle per request
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`
- `redirect`  in  1  flush and restart fetch (one-cycle pulse)
- `redirect_pc`  in  W  restart address
- `id_valid`  out  1  queue head valid to decode
- `id_ready`  in  1  decode accepts head
- `id_inst`  out  32  head instruction
- `id_pc`  out  W  head instruction address

## Operation
- FSM states: IDLE, WAIT, DROP.
- `space` = (queue count + outstanding) < DEPTH, where outstanding is 1 in WAIT and DROP.
- IDLE:
  - If `space` and no `redirect` this cycle, register `imem_addr`←`pc`, set `imem_req`, go to WAIT.
  - `redirect` in IDLE forbids issue that cycle.
- WAIT:
  - `imem_req` and `imem_addr` are held stable until `imem_ack`.
  - On `imem_ack` without `redirect`: push {`imem_addr`, `imem_rdata`}, assert `PCWrite` with `n_pc`=`imem_addr`+4 (mod 2^W), drop `imem_req`, go to IDLE.
- DROP:
  - The request is still outstanding but stale.
  - Hold `imem_req` until `imem_ack`, discard the data, no `PCWrite`, go to IDLE.
- `redirect`, any state:
  - `PCWrite`=1, `n_pc`=`redirect_pc`, and the queue is cleared.
  - From WAIT without `imem_ack`, go to DROP.
  - From WAIT with `imem_ack`, the data is discarded and the FSM goes to IDLE.
  - In DROP, stay in DROP, or go to IDLE if `imem_ack` arrives the same cycle.
- `redirect` has priority over sequential `PCWrite`, push, and pop.
- Queue:
  - FIFO with wrapping read/write pointers.
  - `id_valid` = count≠0; `id_inst`/`id_pc` = head entry.
  - Pop on `id_valid`&&`id_ready`.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by the `space` rule.
- When `PCWrite`=0, `n_pc`=`pc`.

## Timing
- Reset (`rst`=0, asynchronous):
  - State IDLE, queue empty, pointers 0, storage 0.
  - `imem_req`=0, `imem_addr`=0, `id_valid`=0, `id_inst`=0, `id_pc`=0, `PCWrite`=0, `n_pc`=`pc`.
- Reset mid-request abandons it. Memory must tolerate a dropped request.
- Issue: `imem_req` rises on the clock edge after the IDLE cycle in which `space` holds.
- The ack cycle drives `PCWrite`, and the updated `pc` is visible the next cycle. That IDLE cycle issues at the new `pc`.
- Minimum spacing is 2 cycles per instruction when memory acks in the first WAIT cycle.
- Pushed data appears on `id_*` the cycle after the ack.
- `PCWrite`, `n_pc`, `id_valid`, `id_inst`, and `id_pc` are combinational from state, queue, and inputs. No combinational path exists from `id_ready` to `imem_req`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds outputs `perf_fetch_cnt` [31:0] (increments per pop) and `perf_flush_cnt` [31:0] (increments by entries cleared plus 1 per discarded ack).
  - Both counters wrap at 2^32 and reset to 0.
- `FETCH_PERF_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Sequential fetch: `pc`=0x100, memory acks after 1 cycle, `id_ready`=1 → `id_pc` 0x100, 0x104, 0x108, with `n_pc` 0x104, 0x108, 0x10C on the ack cycles.
- Backpressure: `id_ready`=0, DEPTH=2 → exactly 2 entries queued, `imem_req` stays 0, and no third `PCWrite`. Releasing `id_ready` drains both in order.
- Redirect during WAIT: `redirect` with `redirect_pc`=0x200 while a request to 0x108 is pending → DROP, the late ack is discarded, and the next `imem_addr` is 0x200.
- Redirect coincident with ack and pop: `redirect` and `imem_ack` in the same cycle → queue is empty next cycle, `n_pc`=`redirect_pc`, and no push occurs.
- Async reset asserted while in WAIT with 1 queued entry → `imem_req` and `id_valid` go to 0 immediately. After release, fetch restarts from `pc`.
- `FETCH_PERF_EN`: 3 pops, then a redirect with 2 queued entries plus an outstanding request → `perf_fetch_cnt`=3, `perf_flush_cnt`=3.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage placed directly after the program counter register.
// It issues one request/acknowledge read at a time to instruction memory,
// parks the returned words in a small FIFO for decode, and drives the PC
// register write port for sequential advance and for redirects.
//
// Optional build macro:
//   FETCH_PERF_EN  - adds perf_fetch_cnt / perf_flush_cnt outputs and counters.
//                    When undefined the ports and counters do not exist and
//                    fetch behaviour is unchanged.
//
// Parameters:
//   W      address / PC width
//   DEPTH  fetch queue entries (power of two, >= 2)
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   pc             current PC from the PC register
//   PCWrite/n_pc   PC register write enable and next value
//   imem_req       read request, held until imem_ack
//   imem_addr      registered request address
//   imem_ack       one-cycle response strobe per request
//   imem_rdata     instruction word, valid with imem_ack
//   redirect       one-cycle flush/restart pulse
//   redirect_pc    restart address
//   id_valid       queue head valid to decode
//   id_ready       decode accepts head
//   id_inst/id_pc  head instruction and its address
//   perf_*         (FETCH_PERF_EN only) pop count, flushed-entry count
// -----------------------------------------------------------------------------
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no request outstanding; issue at pc when the queue has room
// WAIT   | request outstanding, its data will be queued on imem_ack
// DROP   | request outstanding but made stale by a redirect; data discarded
//
module fetch_unit #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] pc,
   output logic         PCWrite,
   output logic [W-1:0] n_pc,
   output logic         imem_req,
   output logic [W-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   input  logic         redirect,
   input  logic [W-1:0] redirect_pc,
   output logic         id_valid,
   input  logic         id_ready,
   output logic [31:0]  id_inst,
   output logic [W-1:0] id_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]  perf_fetch_cnt,
   output logic [31:0]  perf_flush_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [W-1:0]   addr_q, addr_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [31:0]    inst_q [DEPTH];
   logic [W-1:0]   ipc_q  [DEPTH];

   logic           outstanding;
   logic [CW-1:0]  occupancy;
   logic           space;
   logic           push;
   logic           pop;

   // An outstanding request reserves a queue slot, so a push can never
   // find the queue full.
   assign outstanding = (state_q != S_IDLE);
   assign occupancy   = count_q + CW'(outstanding);
   assign space       = (occupancy < CW'(DEPTH));

   assign imem_req  = outstanding;
   assign imem_addr = addr_q;

   assign id_valid = (count_q != '0);
   assign id_inst  = inst_q[rd_ptr_q];
   assign id_pc    = ipc_q[rd_ptr_q];

   // redirect wins over pop; id_ready never reaches the issue decision,
   // which only looks at registered occupancy.
   assign pop = id_valid && id_ready && !redirect;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      PCWrite = 1'b0;
      n_pc    = pc;
      push    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (space && !redirect) begin
               addr_d  = pc;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               state_d = S_IDLE;
               if (!redirect) begin
                  push    = 1'b1;
                  PCWrite = 1'b1;
                  n_pc    = addr_q + W'(4);
               end
            end else if (redirect) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_ack) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (redirect) begin
         PCWrite = 1'b1;
         n_pc    = redirect_pc;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (redirect) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_q[i] <= '0;
            ipc_q[i]  <= '0;
         end
      end else if (push) begin
         inst_q[wr_ptr_q] <= imem_rdata;
         ipc_q[wr_ptr_q]  <= addr_q;
      end
   end

`ifdef FETCH_PERF_EN
   logic        discard_ack;
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_flush_q;

   // An ack is thrown away when it belongs to a stale request or when it
   // collides with the redirect itself.
   assign discard_ack = imem_ack &&
                        ((state_q == S_DROP) || ((state_q == S_WAIT) && redirect));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (pop) begin
            perf_fetch_q <= perf_fetch_q + 32'd1;
         end
         perf_flush_q <= perf_flush_q
                       + (redirect ? 32'(count_q) : 32'd0)
                       + 32'(discard_ack);
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PERF_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 2;
`endif
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] pc;
   logic         PCWrite;
   logic [W-1:0] n_pc;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_ack;
   logic [31:0]  imem_rdata;
   logic         redirect;
   logic [W-1:0] redirect_pc;
   logic         id_valid;
   logic         id_ready;
   logic [31:0]  id_inst;
   logic [W-1:0] id_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]  perf_fetch_cnt;
   logic [31:0]  perf_flush_cnt;
`endif

   fetch_unit #(.W(W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .PCWrite     (PCWrite),
      .n_pc        (n_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_inst     (id_inst),
      .id_pc       (id_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [31:0]  inst;
   } entry_t;

   entry_t       sb[$];
   logic [W-1:0] popped_pc[$];
   logic [W-1:0] ack_npc[$];
   logic [W-1:0] issued_addr[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic         exp_req;
   logic         stale;
   int           age;
   logic [W-1:0] exp_next_addr;
   logic         pcw_last;
   logic [W-1:0] npc_last;
   int           pcw_count;

   logic         ack_auto;
   int           mem_lat;
   logic         ack_req;
   logic         redir_req;
   logic [W-1:0] redir_pc_req;

   function automatic logic [31:0] mem_word(input logic [W-1:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
   endfunction

   // One clock cycle: entered at posedge+1, drives inputs, models memory and
   // the expected fetch behaviour, checks outputs, returns at next posedge+1.
   task automatic run_cycle();
      logic         ack;
      logic         ack_ok;
      logic         exp_pcw;
      logic         pop;
      logic         issue;
      logic [W-1:0] exp_npc;
      entry_t       e;
      int           size0;

      redirect    = redir_req;
      redirect_pc = redir_pc_req;
      redir_req   = 1'b0;
      ack         = 1'b0;
      if (imem_req) begin
         if (age == 0) begin
            issued_addr.push_back(imem_addr);
            n_checks++;
            if (imem_addr !== exp_next_addr) begin
               n_fail++;
               $display("FAIL issue_addr: got %h expected %h", imem_addr, exp_next_addr);
            end
         end
         age++;
         ack = ack_auto ? (age >= mem_lat) : ack_req;
      end
      ack_req    = 1'b0;
      imem_ack   = ack;
      imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      #1;

      size0 = sb.size();
      n_checks++;
      if (imem_req !== exp_req) begin
         n_fail++;
         $display("FAIL imem_req: got %b expected %b", imem_req, exp_req);
      end
      n_checks++;
      if (id_valid !== (size0 != 0)) begin
         n_fail++;
         $display("FAIL id_valid: got %b expected %b", id_valid, (size0 != 0));
      end
      if (size0 != 0) begin
         n_checks++;
         if (id_pc !== sb[0].pc || id_inst !== sb[0].inst) begin
            n_fail++;
            $display("FAIL id_head: got pc %h inst %h expected pc %h inst %h",
                     id_pc, id_inst, sb[0].pc, sb[0].inst);
         end
      end

      ack_ok  = ack && !stale && !redirect;
      exp_pcw = redirect || ack_ok;
      exp_npc = redirect ? redirect_pc : (ack_ok ? exp_next_addr + 32'd4 : pc);
      n_checks++;
      if (PCWrite !== exp_pcw || n_pc !== exp_npc) begin
         n_fail++;
         $display("FAIL pc_write: got PCWrite %b n_pc %h expected PCWrite %b n_pc %h",
                  PCWrite, n_pc, exp_pcw, exp_npc);
      end
      if (ack_ok) ack_npc.push_back(n_pc);
      if (PCWrite === 1'b1) pcw_count++;

      pop = (size0 != 0) && id_ready && !redirect;
      if (redirect) begin
         sb.delete();
      end else begin
         if (pop) begin
            popped_pc.push_back(id_pc);
            void'(sb.pop_front());
         end
         if (ack_ok) begin
            e.pc   = exp_next_addr;
            e.inst = mem_word(exp_next_addr);
            sb.push_back(e);
         end
      end

      issue = !exp_req && (size0 < DEPTH) && !redirect;
      if (redirect)    exp_next_addr = redirect_pc;
      else if (ack_ok) exp_next_addr = exp_next_addr + 32'd4;
      if (ack) begin
         stale = 1'b0;
         age   = 0;
      end else if (redirect && exp_req) begin
         stale = 1'b1;
      end
      if (issue)    exp_req = 1'b1;
      else if (ack) exp_req = 1'b0;

      pcw_last = PCWrite;
      npc_last = n_pc;
      @(posedge clk);
      #1;
      if (pcw_last === 1'b1) pc = npc_last;
   endtask

   task automatic do_reset(input logic [W-1:0] start_pc);
      rst       = 1'b0;
      redirect  = 1'b0;
      imem_ack  = 1'b0;
      redir_req = 1'b0;
      ack_req   = 1'b0;
      pc        = start_pc;
      repeat (2) @(posedge clk);
      #1;
      rst           = 1'b1;
      sb.delete();
      popped_pc.delete();
      ack_npc.delete();
      issued_addr.delete();
      exp_req       = 1'b0;
      stale         = 1'b0;
      age           = 0;
      pcw_last      = 1'b0;
      pcw_count     = 0;
      exp_next_addr = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pc  = 32'h0000_1234;
      #1 rst = 1'b0;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || imem_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_req: got req %b addr %h expected 0 0", imem_req, imem_addr);
      end
      n_checks++;
      if (id_valid !== 1'b0 || id_inst !== '0 || id_pc !== '0) begin
         n_fail++;
         $display("FAIL reset_id: got valid %b inst %h pc %h expected 0 0 0", id_valid, id_inst, id_pc);
      end
      n_checks++;
      if (PCWrite !== 1'b0 || n_pc !== 32'h0000_1234) begin
         n_fail++;
         $display("FAIL reset_pc: got PCWrite %b n_pc %h expected 0 00001234", PCWrite, n_pc);
      end
      pc = 32'h0000_5678;
      #1;
      n_checks++;
      if (n_pc !== 32'h0000_5678) begin
         n_fail++;
         $display("FAIL reset_npc_follow: got %h expected 00005678", n_pc);
      end
   endtask

   task automatic test_sequential();
      int cyc = 0;
      do_reset(32'h0000_0100);
      ack_auto = 1'b1;
      mem_lat  = 1;
      id_ready = 1'b1;
      while (popped_pc.size() < 3 && cyc < 40) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < 3 || cyc != 7) begin
         n_fail++;
         $display("FAIL seq_timing: got %0d pops in %0d cycles expected 3 in 7", popped_pc.size(), cyc);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (popped_pc[i] !== 32'h100 + 32'(4 * i) || ack_npc[i] !== 32'h104 + 32'(4 * i)) begin
               n_fail++;
               $display("FAIL seq_order[%0d]: got id_pc %h n_pc %h expected %h %h", i,
                        popped_pc[i], ack_npc[i], 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc = 0;
      do_reset(32'h0000_0100);
      ack_auto = 1'b1;
      mem_lat  = 1;
      id_ready = 1'b0;
      repeat (4 * DEPTH + 6) run_cycle();
      n_checks++;
      if (id_valid !== 1'b1 || imem_req !== 1'b0 || pcw_count != DEPTH || issued_addr.size() != DEPTH) begin
         n_fail++;
         $display("FAIL bp_full: got valid %b req %b pcwrites %0d issues %0d expected 1 0 %0d %0d",
                  id_valid, imem_req, pcw_count, issued_addr.size(), DEPTH, DEPTH);
      end
      id_ready = 1'b1;
      while (popped_pc.size() < DEPTH && cyc < 40) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < DEPTH) begin
         n_fail++;
         $display("FAIL bp_drain: got %0d pops expected %0d", popped_pc.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (popped_pc[i] !== 32'h100 + 32'(4 * i)) begin
               n_fail++;
               $display("FAIL bp_order[%0d]: got %h expected %h", i, popped_pc[i], 32'h100 + 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_redirect_wait();
      int cyc = 0;
      do_reset(32'h0000_0100);
      ack_auto = 1'b1;
      mem_lat  = 3;
      id_ready = 1'b1;
      while (!(imem_req === 1'b1 && imem_addr === 32'h108) && cyc < 60) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (cyc >= 60) begin
         n_fail++;
         $display("FAIL rw_timeout: got no request to 00000108 expected one");
      end
      redir_req    = 1'b1;
      redir_pc_req = 32'h0000_0200;
      run_cycle();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
         n_fail++;
         $display("FAIL rw_drop_hold: got req %b addr %h expected 1 00000108", imem_req, imem_addr);
      end
      cyc = 0;
      while (popped_pc.size() < 3 && cyc < 40) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < 3 || issued_addr.size() < 4) begin
         n_fail++;
         $display("FAIL rw_restart: got %0d pops %0d issues expected 3 4", popped_pc.size(), issued_addr.size());
      end else if (popped_pc[2] !== 32'h200 || issued_addr[3] !== 32'h200 || issued_addr[2] !== 32'h108) begin
         n_fail++;
         $display("FAIL rw_restart: got pop %h issue %h after %h expected 00000200 00000200 after 00000108",
                  popped_pc[2], issued_addr[3], issued_addr[2]);
      end
   endtask

   task automatic test_redirect_ack();
      int cyc = 0;
      do_reset(32'h0000_0300);
      ack_auto = 1'b0;
      id_ready = 1'b0;
      run_cycle();
      ack_req = 1'b1;
      run_cycle();
      run_cycle();
      n_checks++;
      if (id_valid !== 1'b1 || imem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL ra_setup: got valid %b req %b expected 1 1", id_valid, imem_req);
      end
      id_ready     = 1'b1;
      ack_req      = 1'b1;
      redir_req    = 1'b1;
      redir_pc_req = 32'h0000_0400;
      run_cycle();
      n_checks++;
      if (id_valid !== 1'b0 || popped_pc.size() != 0 || pc !== 32'h400) begin
         n_fail++;
         $display("FAIL ra_flush: got valid %b pops %0d pc %h expected 0 0 00000400",
                  id_valid, popped_pc.size(), pc);
      end
      ack_auto = 1'b1;
      mem_lat  = 1;
      while (popped_pc.size() < 1 && cyc < 20) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < 1 || popped_pc[0] !== 32'h400) begin
         n_fail++;
         $display("FAIL ra_restart: got %0d pops expected first id_pc 00000400", popped_pc.size());
      end
   endtask

   task automatic test_async_reset();
      int cyc = 0;
      do_reset(32'h0000_0500);
      ack_auto = 1'b0;
      id_ready = 1'b0;
      run_cycle();
      ack_req = 1'b1;
      run_cycle();
      run_cycle();
      run_cycle();
      n_checks++;
      if (imem_req !== 1'b1 || id_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL ar_setup: got req %b valid %b expected 1 1", imem_req, id_valid);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (imem_req !== 1'b0 || id_valid !== 1'b0 || imem_addr !== '0 || PCWrite !== 1'b0 || n_pc !== pc) begin
         n_fail++;
         $display("FAIL ar_immediate: got req %b valid %b addr %h PCWrite %b n_pc %h expected 0 0 0 0 %h",
                  imem_req, id_valid, imem_addr, PCWrite, n_pc, pc);
      end
      do_reset(pc);
      ack_auto = 1'b1;
      mem_lat  = 1;
      id_ready = 1'b1;
      while (popped_pc.size() < 1 && cyc < 20) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < 1 || popped_pc[0] !== 32'h504 || issued_addr[0] !== 32'h504) begin
         n_fail++;
         $display("FAIL ar_restart: got %0d pops expected first fetch at 00000504", popped_pc.size());
      end
   endtask

   task automatic test_wrap();
      int cyc = 0;
      do_reset(32'hFFFF_FFFC);
      ack_auto = 1'b1;
      mem_lat  = 1;
      id_ready = 1'b1;
      while (popped_pc.size() < 2 && cyc < 20) begin
         run_cycle();
         cyc++;
      end
      n_checks++;
      if (popped_pc.size() < 2 || popped_pc[0] !== 32'hFFFF_FFFC || popped_pc[1] !== 32'h0 || ack_npc[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap: got %0d pops expected FFFFFFFC then 00000000 with n_pc 00000000", popped_pc.size());
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      int cyc = 0;
      do_reset(32'h0000_0700);
      ack_auto = 1'b1;
      mem_lat  = 1;
      id_ready = 1'b1;
      while (popped_pc.size() < 3 && cyc < 40) begin
         run_cycle();
         cyc++;
      end
      id_ready = 1'b0;
      cyc = 0;
      while (!(sb.size() == 2 && imem_req === 1'b1) && cyc < 40) begin
         run_cycle();
         cyc++;
      end
      ack_auto     = 1'b0;
      redir_req    = 1'b1;
      redir_pc_req = 32'h0000_0800;
      run_cycle();
      ack_auto = 1'b1;
      repeat (3) run_cycle();
      n_checks++;
      if (perf_fetch_cnt !== 32'd3 || perf_flush_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL perf: got fetch %0d flush %0d expected 3 3", perf_fetch_cnt, perf_flush_cnt);
      end
   endtask
`endif

   initial begin
      redirect     = 1'b0;
      redirect_pc  = '0;
      imem_ack     = 1'b0;
      imem_rdata   = '0;
      id_ready     = 1'b0;
      ack_auto     = 1'b1;
      mem_lat      = 1;
      ack_req      = 1'b0;
      redir_req    = 1'b0;
      redir_pc_req = '0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_wait();
      test_redirect_ack();
      test_async_reset();
      test_wrap();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
